// File: rtl/act_pkg.sv
// act_pkg: shared types for the streaming activation engine.
//   state_t : controller states (idle, word read, word write, finished)
//   mode_t  : run-time activation selector, encoded to match the 2-bit mode port
package act_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    READ     = 2'b01,
    WRITE    = 2'b10,
    FINISHED = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    ACT_RELU   = 2'b00,
    ACT_LEAKY  = 2'b01,
    ACT_CLAMP  = 2'b10,
    ACT_BYPASS = 2'b11
  } mode_t;

endpackage

// File: rtl/act_lane.sv
// act_lane: combinational activation of one signed element.
// Ports:
//   mode      - selected activation (ReLU / leaky / clamp / bypass)
//   clamp_max - clamp-mode upper bound, taken as a positive value
//   valid     - lane holds a real element; padding lanes output 0
//   x         - input element (signed, DATA_WIDTH bits)
//   y         - activated element
//   changed   - high when a valid lane's output differs from its input
module act_lane
  import act_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LEAK_SHIFT = 3
) (
  input  mode_t                 mode,
  input  logic [DATA_WIDTH-1:0] clamp_max,
  input  logic                  valid,
  input  logic [DATA_WIDTH-1:0] x,
  output logic [DATA_WIDTH-1:0] y,
  output logic                  changed
);

  logic signed [DATA_WIDTH-1:0] xs;
  logic signed [DATA_WIDTH-1:0] cmax;
  logic signed [DATA_WIDTH-1:0] act;

  always_comb begin
    xs   = signed'(x);
    // A bound with the sign bit set would read as negative; saturate it to
    // the largest positive value instead.
    cmax = clamp_max[DATA_WIDTH-1] ? {1'b0, {(DATA_WIDTH-1){1'b1}}}
                                   : signed'(clamp_max);
    act  = xs;
    case (mode)
      ACT_RELU:  if (xs < 0) act = '0;
      // Arithmetic shift rounds toward -inf, so small negatives stay at -1.
      ACT_LEAKY: if (xs < 0) act = xs >>> LEAK_SHIFT;
      ACT_CLAMP: begin
        if (xs < 0)         act = '0;
        else if (xs > cmax) act = cmax;
      end
      default:   act = xs;
    endcase
    y       = valid ? act : '0;
    changed = valid && (act != xs);
  end

endmodule

// File: rtl/act_stream_with_mem.sv
// act_stream_with_mem: streams a CHANNELS x HEIGHT x WIDTH feature map from
// memory one packed word at a time, applies the latched activation to every
// lane and writes the word to the output region (2 cycles per word).
// Ports:
//   clk, rst_n         - clock, synchronous active-low reset
//   start              - begin a run (honoured in IDLE or FINISHED)
//   mode, clamp_max    - activation selection, latched at start
//   input_addr         - word address of first input word
//   output_addr        - word address of first output word
//   done               - run finished
//   busy               - reading or writing
//   sat_count          - number of valid elements altered by the activation
//   mem_w, mem_sel     - memory write strobe / select
//   address_bus        - driven in READ/WRITE, else Z
//   data_bus           - driven in WRITE, else Z (memory drives it in READ)
module act_stream_with_mem
  import act_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 8,
  parameter int DATABUS_WIDTH = 32,
  parameter int HEIGHT        = 4,
  parameter int WIDTH         = 4,
  parameter int CHANNELS      = 2,
  parameter int LEAK_SHIFT    = 3,
  localparam int CNT_W        = $clog2(CHANNELS*HEIGHT*WIDTH+1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [1:0]               mode,
  input  logic [DATA_WIDTH-1:0]    clamp_max,
  input  logic [ADDR_WIDTH-1:0]    input_addr,
  input  logic [ADDR_WIDTH-1:0]    output_addr,
  output logic                     done,
  output logic                     busy,
  output logic [CNT_W-1:0]         sat_count,
  output logic                     mem_w,
  output logic                     mem_sel,
  inout  wire  [ADDR_WIDTH-1:0]    address_bus,
  inout  wire  [DATABUS_WIDTH-1:0] data_bus
);

  localparam int LANES  = DATABUS_WIDTH / DATA_WIDTH;
  localparam int TOTAL  = CHANNELS * HEIGHT * WIDTH;
  localparam int NWORDS = (TOTAL + LANES - 1) / LANES;
  localparam int WORD_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  state_t                   state;
  mode_t                    mode_q;
  logic [DATA_WIDTH-1:0]    clamp_q;
  logic [ADDR_WIDTH-1:0]    rd_ptr;
  logic [ADDR_WIDTH-1:0]    wr_ptr;
  logic [WORD_W-1:0]        word;
  logic [DATABUS_WIDTH-1:0] wbuf;
  logic [DATABUS_WIDTH-1:0] lane_out;
  logic [LANES-1:0]         lane_valid;
  logic [LANES-1:0]         lane_changed;
  logic [CNT_W-1:0]         changed_cnt;

  // One activation unit per lane; lanes past the last element of the map
  // are marked invalid so they write 0 and never count as changed.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign lane_valid[k] = (int'(word) * LANES + k) < TOTAL;

    act_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .LEAK_SHIFT (LEAK_SHIFT)
    ) u_lane (
      .mode      (mode_q),
      .clamp_max (clamp_q),
      .valid     (lane_valid[k]),
      .x         (data_bus[k*DATA_WIDTH +: DATA_WIDTH]),
      .y         (lane_out[k*DATA_WIDTH +: DATA_WIDTH]),
      .changed   (lane_changed[k])
    );
  end

  always_comb begin
    changed_cnt = '0;
    for (int k = 0; k < LANES; k++) begin
      changed_cnt = changed_cnt + CNT_W'(lane_changed[k]);
    end
  end

  // Bus drivers decode the state register only, so they release on the
  // cycle after reset or completion.
  assign address_bus = (state == READ)  ? rd_ptr :
                       (state == WRITE) ? wr_ptr : 'z;
  assign data_bus    = (state == WRITE) ? wbuf : 'z;

  // Controller: outputs are registered alongside the state they belong to.
  // done rises one cycle after FINISHED is entered and drops on restart.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      mode_q    <= ACT_RELU;
      clamp_q   <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      word      <= '0;
      wbuf      <= '0;
      sat_count <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
      mem_w     <= 1'b0;
      mem_sel   <= 1'b0;
    end else begin
      case (state)
        IDLE, FINISHED: begin
          if (start) begin
            mode_q    <= mode_t'(mode);
            clamp_q   <= clamp_max;
            rd_ptr    <= input_addr;
            wr_ptr    <= output_addr;
            word      <= '0;
            sat_count <= '0;
            state     <= READ;
            done      <= 1'b0;
            busy      <= 1'b1;
            mem_sel   <= 1'b1;
            mem_w     <= 1'b0;
          end else begin
            done    <= (state == FINISHED);
            busy    <= 1'b0;
            mem_sel <= 1'b0;
            mem_w   <= 1'b0;
          end
        end
        READ: begin
          wbuf      <= lane_out;
          sat_count <= sat_count + changed_cnt;
          rd_ptr    <= rd_ptr + 1'b1;
          state     <= WRITE;
          mem_w     <= 1'b1;
        end
        default: begin
          wr_ptr <= wr_ptr + 1'b1;
          word   <= word + 1'b1;
          if (word == WORD_W'(NWORDS - 1)) begin
            state   <= FINISHED;
            busy    <= 1'b0;
            mem_sel <= 1'b0;
            mem_w   <= 1'b0;
          end else begin
            state <= READ;
            mem_w <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule
